pulse_pattern_gen: RTL and testbench
====================================

# pulse_pattern_gen

Serial pulse-pattern transmitter producing the single-bit stimulus line `A` consumed by the `colocviu` sequence detector. A controller pushes (level, length) segments through a valid/ready port into a small FIFO. The block replays them back-to-back on `A`, each segment held for exactly its length in clock cycles. It is the driving end of the same serial line, so detector scenarios can run in hardware without a testbench driving `A`.

## Interface
- `LEN_W`, 4: width of the segment length field; lengths 1..2^LEN_W-1 cycles.
- `DEPTH`, 4: segment FIFO depth; must be a power of two, at least 2.
- `clk`  input  1  clock; all state changes on the rising edge.
- `rst_n`  input  1  reset, asynchronous, active-high.
- `cmd_valid`  input  1  segment offered.
- `cmd_ready`  output  1  FIFO can accept; equals !full.
- `cmd_level`  input  1  value driven on `A` for the segment.
- `cmd_len`  input  LEN_W  segment duration in cycles.
- `abort`  input  1  synchronous flush of the FIFO and the current segment.
- `A`  output  1  serial pattern line, registered.
- `busy`  output  1  high while a segment is being driven.
- `done`  output  1  one-cycle pulse when the last queued segment completes.

## Operation
- Write: a segment is accepted on a rising edge when `cmd_valid && cmd_ready`.
  - If `cmd_len == 0`, the segment is accepted but discarded, with no FIFO write and no effect on `A`.
- FIFO: DEPTH entries of {level, len}, with a count register of width log2(DEPTH)+1.
  - Full when count == DEPTH; `cmd_ready` = 0 when full.
  - No same-cycle push-when-full, even if a pop occurs in that cycle.
- State machine has two states, IDLE and RUN. The down-counter `cnt` is LEN_W bits.
- IDLE: `A` = 0, `busy` = 0.
  - If the FIFO is non-empty: pop, `A` <= level, `cnt` <= len-1, go to RUN.
- RUN: `busy` = 1.
  - If `cnt` != 0: `cnt` <= `cnt`-1.
  - Else if the FIFO is non-empty: pop the next segment, `A` <= level, `cnt` <= len-1. There is no gap cycle.
  - Else: `A` <= 0, `done` <= 1 for one cycle, go to IDLE.
- `abort`, sampled high on an edge:
  - Clears the FIFO count and pointers.
  - Forces `A` <= 0, `busy` <= 0, goes to IDLE.
  - No `done` pulse.
  - A write in the same cycle is dropped.
  - `cmd_ready` is 1 from the next cycle.
- Consecutive segments at the same level merge visually on `A`; the total high/low time is the sum of their lengths.
- Reset values: `A` = 0, `busy` = 0, `done` = 0, state IDLE, FIFO empty, so `cmd_ready` = 1. `cnt` = 0.
- Reset mid-operation: reset takes effect immediately (asynchronous) and drops all queued segments.

## Timing
- Latency: a segment accepted at edge N is popped at edge N+1 if the block is IDLE. `A` shows its level from edge N+1.
- Duration: `A` holds a segment's level for exactly `len` cycles, from edge P (pop) to edge P+len.
- Back-to-back segments: the next level appears at edge P+len.
- `done` is high in the cycle following the final edge, aligned with `A` returning to 0.
- `busy` and `A` change on the same edges.
- Throughput: one segment per `len` cycles. A 1-cycle segment stream sustains one pop per cycle.
- Pop and push in the same cycle when not full: count is unchanged and both operations succeed.

## Test plan
- Detector pattern: queue (1,2),(0,4),(1,1),(0,3),(1,3),(0,4),(1,4),(0,4) with a pusher honouring `cmd_ready`.
  - Required: `A` exactly matches 2 high, 4 low, 1 high, 3 low, 3 high, 4 low, 4 high, 4 low with no gaps.
  - One `done` pulse after the 25th cycle.
- Single segment (1,5) while IDLE: `A` rises at the edge after acceptance, stays high 5 cycles, then falls.
  - `busy` is high for 5 cycles; `done` pulses once with `A` = 0.
- FIFO full: hold `cmd_valid` with (1,15) segments.
  - Required: exactly DEPTH+1 accepted before `cmd_ready` drops (one popped immediately).
  - `cmd_ready` returns high one cycle after each pop.
- Zero length: push (1,0) then (1,3). Required: `A` is high for exactly 3 cycles; the zero-length entry is never visible.
- `abort` mid-segment during (1,10) with 2 segments queued.
  - Required: `A` = 0 and `busy` = 0 at the next edge, no `done`, `cmd_ready` = 1, and the queue is empty.
- Async reset in RUN: assert `rst_n` between edges.
  - Required: `A`, `busy` and `done` go to 0 immediately; after release, the block is IDLE with an empty FIFO.

Source files
------------

// File: rtl/pulse_pattern_gen_if.sv
// pulse_pattern_gen_if: valid/ready segment command port
interface pulse_pattern_gen_if #(
    parameter int LEN_W = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_level;
    logic [LEN_W-1:0] cmd_len;

    modport master (output cmd_valid, output cmd_level, output cmd_len, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_level, input cmd_len, output cmd_ready);
endinterface

// File: rtl/pulse_pattern_gen.sv
// pulse_pattern_gen: replays queued (level, length) segments back-to-back on serial line A
module pulse_pattern_gen #(
    parameter int LEN_W = 4,
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    pulse_pattern_gen_if.slave cmd,
    input  logic               abort,
    output logic               A,
    output logic               busy,
    output logic               done
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [LEN_W:0]   mem [DEPTH];
    logic [AW-1:0]    wp;
    logic [AW-1:0]    rp;
    logic [AW:0]      count;
    logic [LEN_W-1:0] cnt;
    logic [LEN_W:0]   head;
    logic             push;
    logic             pop;

    assign cmd.cmd_ready = count != (AW+1)'(DEPTH);
    assign push          = cmd.cmd_valid && cmd.cmd_ready && cmd.cmd_len != '0 && !abort;
    assign pop           = !abort && count != '0 && (state == IDLE || cnt == '0);
    assign head          = mem[rp];

    // segment storage; contents need no reset because count gates every read
    always_ff @(posedge clk)
        if (push) mem[wp] <= {cmd.cmd_level, cmd.cmd_len};

    // FIFO pointers and occupancy, flushed by abort
    always_ff @(posedge clk or posedge rst_n)
        if (rst_n) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else if (abort) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            wp    <= wp + AW'(push);
            rp    <= rp + AW'(pop);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end

    // sequencer: load a segment on pop, count it down, finish with a done pulse
    always_ff @(posedge clk or posedge rst_n)
        if (rst_n) begin
            state <= IDLE;
            A     <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            cnt   <= '0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state <= IDLE;
                A     <= 1'b0;
                busy  <= 1'b0;
                cnt   <= '0;
            end else if (pop) begin
                state <= RUN;
                A     <= head[LEN_W];
                busy  <= 1'b1;
                cnt   <= head[LEN_W-1:0] - 1'b1;
            end else if (state == RUN) begin
                if (cnt != '0) begin
                    cnt <= cnt - 1'b1;
                end else begin
                    state <= IDLE;
                    A     <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
            end
        end
endmodule

// File: tb/tb_pulse_pattern_gen.sv
// tb_pulse_pattern_gen: table-driven and sequence checks for pulse_pattern_gen
module tb_pulse_pattern_gen;
    localparam int LEN_W = 4;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic abort;
    logic A, busy, done;
    int   n_chk = 0;
    int   n_pass = 0;

    pulse_pattern_gen_if #(.LEN_W(LEN_W)) cmd ();

    pulse_pattern_gen #(.LEN_W(LEN_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .cmd   (cmd),
        .abort (abort),
        .A     (A),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic       lvl;
        logic [3:0] len;
        logic       ab;
        logic [3:0] exp;
    } vec_t;

    vec_t tbl [24];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic lvl, input logic [3:0] len, input logic ab);
        cmd.cmd_valid = v;
        cmd.cmd_level = lvl;
        cmd.cmd_len   = len;
        abort         = ab;
    endtask

    function automatic vec_t mk(input logic v, input logic lvl, input logic [3:0] len,
                                input logic ab, input logic [3:0] exp);
        vec_t r;
        r.v = v; r.lvl = lvl; r.len = len; r.ab = ab; r.exp = exp;
        return r;
    endfunction

    logic       a_log [45];
    logic       d_log [45];
    logic       seg_l [8];
    logic [3:0] seg_n [8];
    logic [24:0] expv, gotv;
    int idx, start, pos, dones, acc, low;
    logic rdy, vld;

    initial begin
        // exp = {A, busy, done, cmd_ready} sampled just after the edge
        tbl[0]  = mk(1, 1, 5, 0, 4'b0001);
        tbl[1]  = mk(0, 0, 0, 0, 4'b1101);
        tbl[2]  = mk(0, 0, 0, 0, 4'b1101);
        tbl[3]  = mk(0, 0, 0, 0, 4'b1101);
        tbl[4]  = mk(0, 0, 0, 0, 4'b1101);
        tbl[5]  = mk(0, 0, 0, 0, 4'b1101);
        tbl[6]  = mk(0, 0, 0, 0, 4'b0011);
        tbl[7]  = mk(0, 0, 0, 0, 4'b0001);
        tbl[8]  = mk(1, 1, 0, 0, 4'b0001);
        tbl[9]  = mk(1, 1, 3, 0, 4'b0001);
        tbl[10] = mk(0, 0, 0, 0, 4'b1101);
        tbl[11] = mk(0, 0, 0, 0, 4'b1101);
        tbl[12] = mk(0, 0, 0, 0, 4'b1101);
        tbl[13] = mk(0, 0, 0, 0, 4'b0011);
        tbl[14] = mk(0, 0, 0, 0, 4'b0001);
        tbl[15] = mk(1, 1, 10, 0, 4'b0001);
        tbl[16] = mk(1, 0, 2, 0, 4'b1101);
        tbl[17] = mk(1, 1, 2, 0, 4'b1101);
        tbl[18] = mk(0, 0, 0, 0, 4'b1101);
        tbl[19] = mk(1, 1, 3, 1, 4'b0001);
        tbl[20] = mk(0, 0, 0, 0, 4'b0001);
        tbl[21] = mk(0, 0, 0, 0, 4'b0001);
        tbl[22] = mk(0, 0, 0, 0, 4'b0001);
        tbl[23] = mk(0, 0, 0, 0, 4'b0001);

        seg_l = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        seg_n = '{4'd2, 4'd4, 4'd1, 4'd3, 4'd3, 4'd4, 4'd4, 4'd4};

        rst_n = 1'b1;
        drive(0, 0, 0, 0);
        cyc();
        cyc();
        chk("reset_state", {A, busy, done, cmd.cmd_ready}, 4'b0001);
        rst_n = 1'b0;
        cyc();
        chk("idle_after_reset", {A, busy, done, cmd.cmd_ready}, 4'b0001);

        for (int i = 0; i < 24; i++) begin
            drive(tbl[i].v, tbl[i].lvl, tbl[i].len, tbl[i].ab);
            cyc();
            chk($sformatf("vec%0d", i), {A, busy, done, cmd.cmd_ready}, tbl[i].exp);
        end
        drive(0, 0, 0, 0);
        cyc();

        // detector pattern with a ready-honouring pusher
        idx = 0;
        for (int c = 0; c < 45; c++) begin
            vld = idx < 8;
            drive(vld, vld ? seg_l[idx] : 1'b0, vld ? seg_n[idx] : 4'd0, 0);
            rdy = cmd.cmd_ready;
            cyc();
            if (vld && rdy) idx++;
            a_log[c] = A;
            d_log[c] = done;
        end
        drive(0, 0, 0, 0);
        pos = 0;
        for (int s = 0; s < 8; s++)
            for (int k = 0; k < int'(seg_n[s]); k++) begin
                expv[24 - pos] = seg_l[s];
                pos++;
            end
        start = -1;
        for (int c = 0; c < 45; c++)
            if (start < 0 && a_log[c]) start = c;
        chk("pattern_start", start, 1);
        if (start < 0) start = 1;
        for (int k = 0; k < 25; k++) gotv[24 - k] = a_log[start + k];
        chk("pattern_bits", gotv, expv);
        chk("pattern_end_A", a_log[start + 25], 0);
        chk("pattern_end_done", d_log[start + 25], 1);
        dones = 0;
        for (int c = 0; c < 45; c++) dones += int'(d_log[c]);
        chk("pattern_done_count", dones, 1);

        // FIFO full under a held cmd_valid
        acc = 0;
        drive(1, 1, 15, 0);
        for (int c = 0; c < 20 && cmd.cmd_ready; c++) begin
            cyc();
            acc++;
        end
        chk("full_accept_count", acc, DEPTH + 1);
        chk("full_ready_low", cmd.cmd_ready, 0);
        low = 0;
        for (int c = 0; c < 30 && !cmd.cmd_ready; c++) begin
            cyc();
            low++;
        end
        chk("full_ready_low_cycles", low, 12);
        cyc();
        chk("full_refill", cmd.cmd_ready, 0);
        drive(0, 0, 0, 1);
        cyc();
        chk("full_abort", {A, busy, done, cmd.cmd_ready}, 4'b0001);
        drive(0, 0, 0, 0);
        cyc();

        // asynchronous reset while running
        drive(1, 1, 8, 0);
        cyc();
        drive(1, 0, 8, 0);
        cyc();
        drive(0, 0, 0, 0);
        cyc();
        chk("pre_reset_run", {A, busy}, 2'b11);
        #3;
        rst_n = 1'b1;
        #1;
        chk("async_reset_outputs", {A, busy, done, cmd.cmd_ready}, 4'b0001);
        cyc();
        rst_n = 1'b0;
        for (int c = 0; c < 4; c++) begin
            cyc();
            chk($sformatf("post_reset_idle%0d", c), {A, busy, done, cmd.cmd_ready}, 4'b0001);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
